hbridge_drive_guard: RTL
========================

// Module: hbridge_drive_guard
// PURPOSE
//  Output stage between the rover top-level direction/PWM logic and the H-bridge pins.
//  Takes the per-side direction commands and PWM enables produced upstream.
//  Enforces a dead time on every direction change and never drives fwd+bwd on one side.
//  Latches a per-side overcurrent fault from the bridge sense pins until the operator clears it.
// PARAMETERS
//  DEADTIME_CYC   100_000  clock cycles with both dir pins and enable low between drive states (1 ms @100 MHz)
//  OC_FILTER_CYC  1_000    consecutive cycles of synced oc high needed to declare a fault (10 us)
// PORTS
//  clock          in   1  100 MHz system clock; single clock domain
//  reset          in   1  asynchronous, active-high reset
//  fwd_left_in    in   1  left forward command (upstream Forward_left)
//  bwd_left_in    in   1  left backward command
//  fwd_right_in   in   1  right forward command
//  bwd_right_in   in   1  right backward command
//  pwm_left_in    in   1  left PWM enable (upstream PWM_ENA)
//  pwm_right_in   in   1  right PWM enable (PWM_ENB)
//  oc_left        in   1  left overcurrent sense, async pin, 1 = overcurrent
//  oc_right       in   1  right overcurrent sense, async pin
//  oc_clear       in   1  fault clear button, async, level
//  fwd_left_out   out  1  to H-bridge
//  bwd_left_out   out  1
//  fwd_right_out  out  1
//  bwd_right_out  out  1
//  en_left_out    out  1  gated PWM enable to bridge
//  en_right_out   out  1
//  fault_left     out  1  latched fault, drives LED
//  fault_right    out  1
//  state_left     out  3  debug state code
//  state_right    out  3
// BEHAVIOUR
//  - Per-side FSM: IDLE, DRV_FWD, DRV_BWD, DEAD, FAULT.
//  - Async reset: every output is 0; state = DEAD; dead counter = 0; filter counter = 0.
//    A full dead time therefore elapses after reset release before any drive.
//  - oc_*, oc_clear: 2-FF synchronizers. oc_clear is used as the rising edge of its synced value.
//  - Command decode (unsynced, same domain): fwd&!bwd = FWD; bwd&!fwd = BWD; both or neither = COAST.
//  - IDLE: FWD -> DRV_FWD, BWD -> DRV_BWD.
//  - DRV_x:
//    - Command differs from x (including COAST) -> DEAD, counter cleared.
//    - Same command -> stay.
//  - DEAD:
//    - Counter increments each cycle. On count == DEADTIME_CYC-1, go to the command decoded that cycle:
//      IDLE / DRV_FWD / DRV_BWD.
//    - A command change during DEAD does not restart the count.
//  - Outputs are registered, giving 1 cycle latency from the state decision:
//    - DRV_FWD: fwd = 1, bwd = 0, en = pwm_in delayed 1 cycle.
//    - DRV_BWD: mirror of DRV_FWD.
//    - All other states: fwd = bwd = en = 0.
//  - fwd_out & bwd_out is never 1 on a side, in any cycle.
//  - Fault filter:
//    - The counter increments while synced oc = 1 and clears to 0 when oc = 0; it saturates.
//    - Reaching OC_FILTER_CYC forces FAULT from any state.
//    - Fault has priority over any command or dead-time event in the same cycle.
//  - FAULT: outputs low, fault_x = 1.
//    - Exit only on an oc_clear rising edge while synced oc = 0: go to DEAD (counter 0), fault_x drops.
//    - A clear while oc = 1 is ignored and not remembered.
//    - A clear in the same cycle as filter completion: fault wins.
//  - The two sides are fully independent. One oc_clear edge clears both sides' eligible faults.
//  - Counter widths: $clog2(DEADTIME_CYC+1) and $clog2(OC_FILTER_CYC+1); no wrap.
//  - state codes: IDLE=0, DRV_FWD=1, DRV_BWD=2, DEAD=3, FAULT=4.
// STRUCTURE
//  - rover_defs.vh (shared include): state code localparams and default timing constants.
//    ColorSensorStateMachine debug decoding reuses this file.
//  - Sub-module hbridge_side_ctrl: one side's FSM, dead counter, OC filter and output regs.
//    It is instantiated twice.
//  - The top holds the synchronizers and the oc_clear edge detect.
// TESTING  (sim params DEADTIME_CYC=10, OC_FILTER_CYC=4)
//  1. Release reset with fwd_left_in=1, pwm=1 -> outputs 0 for 10 cycles,
//     then fwd_left_out=en_left_out=1 on cycle 11 (+1 register).
//  2. Steady DRV_FWD, switch to bwd -> next cycle all left outputs 0 for exactly 10 cycles, then bwd_left_out=1.
//     Assert fwd&bwd never high.
//  3. fwd=bwd=1 while in DRV_FWD -> DEAD then IDLE, outputs 0.
//     Toggle back to FWD mid-dead -> count not restarted.
//  4. oc_left high 3 cycles then low -> no fault. High 4+ cycles -> fault_left=1, left outputs 0.
//     Right side is unaffected.
//  5. oc_clear pulse while oc_left=1 -> still FAULT.
//     oc_left=0 then clear pulse -> fault_left=0, 10-cycle dead, drive resumes.
//  6. Assert reset mid-DRV_BWD -> all outputs 0 in the same cycle (async).
//     On release, a full dead time elapses before drive.

Source files
------------

// File: rtl/hbridge_drive_guard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hbridge_drive_guard_pkg
//  Brief    : Shared state codes, default timing constants and command
//             decode helpers for the H-bridge drive guard.
//  Revision : 1.0  initial release
// ============================================================================
package hbridge_drive_guard_pkg;

  // Per-side FSM state codes; these values are also the debug state outputs
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DRV_FWD = 3'd1;
  localparam logic [2:0] ST_DRV_BWD = 3'd2;
  localparam logic [2:0] ST_DEAD    = 3'd3;
  localparam logic [2:0] ST_FAULT   = 3'd4;

  // Default timing at 100 MHz: 1 ms dead time, 10 us overcurrent filter
  localparam int unsigned DEADTIME_CYC_DEF  = 100_000;
  localparam int unsigned OC_FILTER_CYC_DEF = 1_000;

  typedef enum logic [1:0] {
    CMD_COAST = 2'd0,
    CMD_FWD   = 2'd1,
    CMD_BWD   = 2'd2
  } cmd_t;

  // Conflicting or absent direction requests both mean coast
  function automatic cmd_t decode_cmd(input logic fwd, input logic bwd);
    cmd_t c;
    c = CMD_COAST;
    if (fwd && !bwd) begin
      c = CMD_FWD;
    end else if (bwd && !fwd) begin
      c = CMD_BWD;
    end
    return c;
  endfunction

  // State entered when a dead time completes under a given command
  function automatic logic [2:0] cmd_to_state(input cmd_t c);
    logic [2:0] s;
    s = ST_IDLE;
    if (c == CMD_FWD) begin
      s = ST_DRV_FWD;
    end else if (c == CMD_BWD) begin
      s = ST_DRV_BWD;
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hbridge_side_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hbridge_side_ctrl
//  Brief    : One bridge side: drive FSM, dead-time counter, overcurrent
//             filter and registered pin outputs.
//  Revision : 1.0  initial release
// ============================================================================
module hbridge_side_ctrl
  import hbridge_drive_guard_pkg::*;
#(
  parameter int unsigned DEADTIME_CYC  = DEADTIME_CYC_DEF,
  parameter int unsigned OC_FILTER_CYC = OC_FILTER_CYC_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fwd_in,
  input  logic       bwd_in,
  input  logic       pwm_in,
  input  logic       oc_sync,
  input  logic       clear_pulse,
  output logic       fwd_out,
  output logic       bwd_out,
  output logic       en_out,
  output logic       fault,
  output logic [2:0] state_code
);

  localparam int unsigned     DW        = $clog2(DEADTIME_CYC + 1);
  localparam int unsigned     FW        = $clog2(OC_FILTER_CYC + 1);
  localparam logic [DW-1:0]   DEAD_LAST = DW'(DEADTIME_CYC - 1);
  localparam logic [FW-1:0]   FILT_MAX  = FW'(OC_FILTER_CYC);

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [FW-1:0] filt_q, filt_d;
  logic          filt_hit;
  cmd_t          cmd;

  assign cmd = decode_cmd(fwd_in, bwd_in);

  // Overcurrent filter: count consecutive high samples, saturate, drop on low
  always_comb begin
    filt_d = '0;
    if (oc_sync) begin
      filt_d = (filt_q == FILT_MAX) ? filt_q : filt_q + 1'b1;
    end
    filt_hit = oc_sync && (filt_d == FILT_MAX);
  end

  // Next-state logic; a completed filter overrides every other transition
  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    if (filt_hit) begin
      state_d = ST_FAULT;
      dead_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd != CMD_COAST) begin
            state_d = cmd_to_state(cmd);
          end
        end
        ST_DRV_FWD: begin
          if (cmd != CMD_FWD) begin
            state_d = ST_DEAD;
            dead_d  = '0;
          end
        end
        ST_DRV_BWD: begin
          if (cmd != CMD_BWD) begin
            state_d = ST_DEAD;
            dead_d  = '0;
          end
        end
        ST_DEAD: begin
          // Command changes here never restart the count
          if (dead_q == DEAD_LAST) begin
            state_d = cmd_to_state(cmd);
            dead_d  = '0;
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
        ST_FAULT: begin
          // A clear seen while overcurrent persists is dropped, not held
          if (clear_pulse && !oc_sync) begin
            state_d = ST_DEAD;
            dead_d  = '0;
          end
        end
        default: begin
          state_d = ST_DEAD;
          dead_d  = '0;
        end
      endcase
    end
  end

  // State, dead counter and filter counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_DEAD;
      dead_q  <= '0;
      filt_q  <= '0;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
      filt_q  <= filt_d;
    end
  end

  // Registered pins derived from a single state value, so fwd and bwd are exclusive
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fwd_out    <= 1'b0;
      bwd_out    <= 1'b0;
      en_out     <= 1'b0;
      fault      <= 1'b0;
      state_code <= 3'd0;
    end else begin
      fwd_out    <= (state_q == ST_DRV_FWD);
      bwd_out    <= (state_q == ST_DRV_BWD);
      en_out     <= ((state_q == ST_DRV_FWD) || (state_q == ST_DRV_BWD)) && pwm_in;
      fault      <= (state_q == ST_FAULT);
      state_code <= state_q;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hbridge_drive_guard.sv
`default_nettype none
// ============================================================================
//  Module   : hbridge_drive_guard
//  Brief    : H-bridge output guard: synchronizes sense/clear pins and runs
//             an independent dead-time / fault controller per side.
//  Revision : 1.0  initial release
// ============================================================================
module hbridge_drive_guard
  import hbridge_drive_guard_pkg::*;
#(
  parameter int unsigned DEADTIME_CYC  = DEADTIME_CYC_DEF,
  parameter int unsigned OC_FILTER_CYC = OC_FILTER_CYC_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fwd_left_in,
  input  logic       bwd_left_in,
  input  logic       fwd_right_in,
  input  logic       bwd_right_in,
  input  logic       pwm_left_in,
  input  logic       pwm_right_in,
  input  logic       oc_left,
  input  logic       oc_right,
  input  logic       oc_clear,
  output logic       fwd_left_out,
  output logic       bwd_left_out,
  output logic       fwd_right_out,
  output logic       bwd_right_out,
  output logic       en_left_out,
  output logic       en_right_out,
  output logic       fault_left,
  output logic       fault_right,
  output logic [2:0] state_left,
  output logic [2:0] state_right
);

  logic oc_left_meta, oc_left_sync;
  logic oc_right_meta, oc_right_sync;
  logic clr_meta, clr_sync, clr_prev;
  logic clear_pulse;

  // Two-flop synchronizers for the asynchronous pins, plus clear edge history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oc_left_meta  <= 1'b0;
      oc_left_sync  <= 1'b0;
      oc_right_meta <= 1'b0;
      oc_right_sync <= 1'b0;
      clr_meta      <= 1'b0;
      clr_sync      <= 1'b0;
      clr_prev      <= 1'b0;
    end else begin
      oc_left_meta  <= oc_left;
      oc_left_sync  <= oc_left_meta;
      oc_right_meta <= oc_right;
      oc_right_sync <= oc_right_meta;
      clr_meta      <= oc_clear;
      clr_sync      <= clr_meta;
      clr_prev      <= clr_sync;
    end
  end

  // One clear press yields a single-cycle pulse shared by both sides
  assign clear_pulse = clr_sync && !clr_prev;

  hbridge_side_ctrl #(
    .DEADTIME_CYC  (DEADTIME_CYC),
    .OC_FILTER_CYC (OC_FILTER_CYC)
  ) u_left (
    .clock       (clock),
    .reset       (reset),
    .fwd_in      (fwd_left_in),
    .bwd_in      (bwd_left_in),
    .pwm_in      (pwm_left_in),
    .oc_sync     (oc_left_sync),
    .clear_pulse (clear_pulse),
    .fwd_out     (fwd_left_out),
    .bwd_out     (bwd_left_out),
    .en_out      (en_left_out),
    .fault       (fault_left),
    .state_code  (state_left)
  );

  hbridge_side_ctrl #(
    .DEADTIME_CYC  (DEADTIME_CYC),
    .OC_FILTER_CYC (OC_FILTER_CYC)
  ) u_right (
    .clock       (clock),
    .reset       (reset),
    .fwd_in      (fwd_right_in),
    .bwd_in      (bwd_right_in),
    .pwm_in      (pwm_right_in),
    .oc_sync     (oc_right_sync),
    .clear_pulse (clear_pulse),
    .fwd_out     (fwd_right_out),
    .bwd_out     (bwd_right_out),
    .en_out      (en_right_out),
    .fault       (fault_right),
    .state_code  (state_right)
  );

endmodule
`default_nettype wire
